// File: rtl/sqrt_iter_param.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_iter_param
// Purpose  : Iterative non-restoring integer square root.
//            sqr_root = floor(sqrt(data_in)), remainder = data_in - sqr_root^2.
//            Resolves ITER_PER_CYC root bits per clock, start/finish handshake.
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_iter_param #(
  parameter int DATA_W       = 16,
  parameter int ITER_PER_CYC = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   data_in,
  output logic                busy,
  output logic                finish,
  output logic [DATA_W/2-1:0] sqr_root,
  output logic [DATA_W/2:0]   remainder
);

  localparam int ROOT_W = DATA_W / 2;
  localparam int REM_W  = ROOT_W + 2;            // signed partial remainder
  localparam int ITERS  = ROOT_W / ITER_PER_CYC;
  localparam int CNT_W  = (ITERS > 1) ? $clog2(ITERS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rad_q;    // radicand, consumed MSB pair first
  logic [ROOT_W-1:0] root_q;   // working root
  logic [REM_W-1:0]  prem_q;   // working partial remainder (two's complement)

  logic [DATA_W-1:0] rad_n;
  logic [ROOT_W-1:0] root_n;
  logic [REM_W-1:0]  prem_n;
  logic [REM_W-1:0]  shifted;
  logic [ROOT_W:0]   fix_rem;

  // ITER_PER_CYC chained non-restoring digit steps, plus the final correction.
  // Intermediate shifts may wrap, but every sign that steers a decision and the
  // corrected final remainder are in range, so modular arithmetic stays exact.
  always_comb begin
    rad_n   = rad_q;
    root_n  = root_q;
    prem_n  = prem_q;
    shifted = '0;
    for (int i = 0; i < ITER_PER_CYC; i++) begin
      shifted = {prem_n[REM_W-3:0], rad_n[DATA_W-1 -: 2]};
      if (!prem_n[REM_W-1]) begin
        prem_n = shifted - {root_n, 2'b01};
      end else begin
        prem_n = shifted + {root_n, 2'b11};
      end
      root_n = {root_n[ROOT_W-2:0], ~prem_n[REM_W-1]};
      rad_n  = {rad_n[DATA_W-3:0], 2'b00};
    end
    fix_rem = prem_n[ROOT_W:0] + (prem_n[REM_W-1] ? {root_n, 1'b1} : '0);
  end

  // Control FSM, working registers and held results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rad_q     <= '0;
      root_q    <= '0;
      prem_q    <= '0;
      busy      <= 1'b0;
      finish    <= 1'b0;
      sqr_root  <= '0;
      remainder <= '0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= CALC;
            busy   <= 1'b1;
            rad_q  <= data_in;
            root_q <= '0;
            prem_q <= '0;
            cnt    <= CNT_W'(ITERS - 1);
          end
        end
        CALC: begin
          rad_q  <= rad_n;
          root_q <= root_n;
          prem_q <= prem_n;
          if (cnt == '0) begin
            sqr_root  <= root_n;
            remainder <= fix_rem;
            finish    <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
